// File: rtl/loop_pwm_gate_sequencer.sv
// PWM modulator and non-overlapping high/low gate sequencer for the step-down control loop.
// Includes a cycle-by-cycle over-current limit and a sticky fault latch after repeated trips.
module loop_pwm_gate_sequencer #(
  parameter int CNT_W    = 8,
  parameter int PERIOD   = 200,
  parameter int DEAD_W   = 4,
  parameter int DEAD_RST = 2,
  parameter int OCP_LIM  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CELV,
  input  logic              CELG,
  input  logic              SUB,
  input  logic              en,
  input  logic [CNT_W-1:0]  duty_in,
  input  logic [DEAD_W-1:0] dead_in,
  input  logic              duty_vld,
  output logic              duty_rdy,
  input  logic              ocp,
  input  logic              fault_clr,
  output logic              hs_on,
  output logic              ls_on,
  output logic              prd_start,
  output logic              fault
);

  localparam int EW    = ((CNT_W > DEAD_W) ? CNT_W : DEAD_W) + 2;
  localparam int RUN_W = (OCP_LIM > 1) ? $clog2(OCP_LIM + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [EW-1:0]    PERIOD_E = EW'(PERIOD);
  localparam logic [RUN_W-1:0] RUN_LIM  = RUN_W'(OCP_LIM);

  typedef enum logic [2:0] {
    ST_OFF = 3'd0,
    ST_DLH = 3'd1,
    ST_HS  = 3'd2,
    ST_DHL = 3'd3,
    ST_LS  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  r_duty_act;
  logic [CNT_W-1:0]  r_duty_sh;
  logic [DEAD_W-1:0] r_dead_act;
  logic [DEAD_W-1:0] r_dead_sh;
  logic              r_full;
  logic              w_full_nxt;
  logic [EW-1:0]     r_ls_at;
  logic [EW-1:0]     w_ls_at_nxt;
  logic              r_ocp_hit;
  logic              w_ocp_hit_nxt;
  logic [RUN_W-1:0]  r_ocp_run;
  logic [RUN_W-1:0]  w_ocp_run_nxt;
  logic [RUN_W-1:0]  w_run_inc;
  logic              r_fault;
  logic              w_fault_nxt;
  logic              r_hs;
  logic              r_ls;
  logic              r_prd;
  logic              r_rdy;

  logic              w_take;
  logic              w_running;
  logic              w_wrap;
  logic              w_ocp_evt;
  logic              w_trip;
  logic              w_go;
  logic              w_start;
  logic              w_load;
  logic [CNT_W-1:0]  w_duty_nxt;
  logic [DEAD_W-1:0] w_dead_nxt;
  logic [EW-1:0]     w_duty_e;
  logic [EW-1:0]     w_dead_e;
  logic [EW-1:0]     w_two_dead;
  logic [EW-1:0]     w_lim;
  logic [EW-1:0]     w_min;
  logic [EW-1:0]     w_eff;
  logic [EW-1:0]     w_cnt_e;
  logic              w_unused_pins;

  assign w_unused_pins = CELV ^ CELG ^ SUB;

  assign duty_rdy  = r_rdy;
  assign hs_on     = r_hs;
  assign ls_on     = r_ls;
  assign prd_start = r_prd;
  assign fault     = r_fault;

  // Handshake, period sequencing, over-current bookkeeping and fault latch decisions
  always_comb begin
    w_take    = duty_vld && !r_full;
    w_running = (r_state != ST_OFF);
    w_wrap    = w_running && (r_cnt == CNT_LAST);
    w_ocp_evt = ocp && ((r_state == ST_DLH) || (r_state == ST_HS));
    w_run_inc = r_ocp_run + RUN_W'(1);
    w_trip    = w_ocp_evt && (w_run_inc == RUN_LIM);

    if (w_trip) begin
      w_fault_nxt = 1'b1;
    end else if (fault_clr) begin
      w_fault_nxt = 1'b0;
    end else begin
      w_fault_nxt = r_fault;
    end

    // A new period begins on a wrap or on restart out of OFF; both adopt a pending command.
    w_go    = en && !w_fault_nxt;
    w_start = w_go && (!w_running || w_wrap);
    w_load  = w_start && r_full;

    if (w_take) begin
      w_full_nxt = 1'b1;
    end else if (w_load) begin
      w_full_nxt = 1'b0;
    end else begin
      w_full_nxt = r_full;
    end

    if (w_ocp_evt) begin
      w_ocp_run_nxt = w_run_inc;
    end else if (fault_clr) begin
      w_ocp_run_nxt = {RUN_W{1'b0}};
    end else if (w_wrap && !r_ocp_hit) begin
      w_ocp_run_nxt = {RUN_W{1'b0}};
    end else begin
      w_ocp_run_nxt = r_ocp_run;
    end

    if (!w_go || w_start) begin
      w_ocp_hit_nxt = 1'b0;
    end else if (w_ocp_evt) begin
      w_ocp_hit_nxt = 1'b1;
    end else begin
      w_ocp_hit_nxt = r_ocp_hit;
    end

    if (!w_go) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else if (w_start) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
    w_cnt_e = EW'(w_cnt_nxt);
  end

  // Duty clamp on the command that will be active next cycle
  always_comb begin
    w_duty_nxt = w_load ? r_duty_sh : r_duty_act;
    w_dead_nxt = w_load ? r_dead_sh : r_dead_act;
    w_duty_e   = EW'(w_duty_nxt);
    w_dead_e   = EW'(w_dead_nxt);
    w_two_dead = w_dead_e << 1'b1;
    if (w_two_dead >= PERIOD_E) begin
      w_lim = {EW{1'b0}};
    end else begin
      w_lim = PERIOD_E - w_two_dead;
    end
    w_min = (w_duty_e < w_lim) ? w_duty_e : w_lim;
    // A high-side pulse no longer than the dead time is dropped entirely.
    if (w_min <= w_dead_e) begin
      w_eff = {EW{1'b0}};
    end else begin
      w_eff = w_min;
    end
  end

  // Gate FSM next state, evaluated against the counter value of the next cycle
  always_comb begin
    w_state_nxt = r_state;
    w_ls_at_nxt = r_ls_at;
    if (!w_go) begin
      w_state_nxt = ST_OFF;
    end else if (w_start) begin
      w_ls_at_nxt = w_eff + w_dead_e;
      if (w_eff == {EW{1'b0}}) begin
        w_state_nxt = ST_LS;
      end else if (w_dead_e == {EW{1'b0}}) begin
        w_state_nxt = ST_HS;
      end else begin
        w_state_nxt = ST_DLH;
      end
    end else if (w_ocp_evt) begin
      // Over-current cuts the high side now and inserts a full dead gap before LS.
      w_ls_at_nxt = w_cnt_e + w_dead_e;
      if (w_dead_e == {EW{1'b0}}) begin
        w_state_nxt = ST_LS;
      end else begin
        w_state_nxt = ST_DHL;
      end
    end else begin
      case (r_state)
        ST_DLH: begin
          if (w_cnt_e == w_dead_e) begin
            w_state_nxt = ST_HS;
          end else begin
            w_state_nxt = ST_DLH;
          end
        end
        ST_HS: begin
          if (w_cnt_e != w_eff) begin
            w_state_nxt = ST_HS;
          end else if (w_dead_e == {EW{1'b0}}) begin
            w_state_nxt = ST_LS;
          end else begin
            w_state_nxt = ST_DHL;
          end
        end
        ST_DHL: begin
          if (w_cnt_e == r_ls_at) begin
            w_state_nxt = ST_LS;
          end else begin
            w_state_nxt = ST_DHL;
          end
        end
        ST_LS: begin
          w_state_nxt = ST_LS;
        end
        default: begin
          w_state_nxt = ST_OFF;
        end
      endcase
    end
  end

  // State, counter, command and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_OFF;
      r_cnt      <= {CNT_W{1'b0}};
      r_duty_act <= {CNT_W{1'b0}};
      r_dead_act <= DEAD_W'(DEAD_RST);
      r_duty_sh  <= {CNT_W{1'b0}};
      r_dead_sh  <= {DEAD_W{1'b0}};
      r_full     <= 1'b0;
      r_ls_at    <= {EW{1'b0}};
      r_ocp_hit  <= 1'b0;
      r_ocp_run  <= {RUN_W{1'b0}};
      r_fault    <= 1'b0;
      r_hs       <= 1'b0;
      r_ls       <= 1'b0;
      r_prd      <= 1'b0;
      r_rdy      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_full    <= w_full_nxt;
      r_ls_at   <= w_ls_at_nxt;
      r_ocp_hit <= w_ocp_hit_nxt;
      r_ocp_run <= w_ocp_run_nxt;
      r_fault   <= w_fault_nxt;
      r_hs      <= (w_state_nxt == ST_HS);
      r_ls      <= (w_state_nxt == ST_LS);
      r_prd     <= w_start;
      r_rdy     <= !w_full_nxt;
      if (w_take) begin
        r_duty_sh <= duty_in;
        r_dead_sh <= dead_in;
      end
      if (w_load) begin
        r_duty_act <= r_duty_sh;
        r_dead_act <= r_dead_sh;
      end
    end
  end

endmodule
